// File: rtl/systolic_job_controller.sv
// Control sequencer for one N x N systolic matrix-multiply job: loads A rows into the
// skew buffer, streams them through the array, captures skewed results and drains C rows.
module systolic_job_controller #(
    parameter int ARRAY_SIZE    = 8,
    parameter int ARRAY_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          arr_clear,
    input  logic                          a_valid,
    output logic                          a_ready,
    output logic                          sb_write,
    output logic [$clog2(ARRAY_SIZE)-1:0] sb_row_ptr,
    output logic                          sb_enable,
    output logic                          rsb_enable,
    output logic                          rsb_write,
    output logic                          rsb_read,
    output logic                          c_valid,
    input  logic                          c_ready,
    output logic [$clog2(ARRAY_SIZE)-1:0] c_row_idx
);

    localparam int N           = ARRAY_SIZE;
    localparam int IW          = $clog2(N);
    localparam int PW          = $clog2(2 * N);
    localparam int WAIT_CYCLES = N - 1 + ARRAY_LATENCY;

    localparam logic [PW-1:0] SKEW_LAST = PW'(2 * N - 2);
    localparam logic [PW-1:0] WAIT_LAST = PW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [IW-1:0] ROW_LAST  = IW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_WAIT,
        S_UNLOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   phase_cnt;
    logic [IW-1:0]   load_cnt;
    logic [IW-1:0]   drain_cnt;
    logic            phase_run;

    assign phase_run = (state == S_STREAM) || (state == S_WAIT) || (state == S_UNLOAD);

    // Every counter restarts at zero whenever the state changes, so no counter wraps in a state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            load_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                phase_cnt <= '0;
                load_cnt  <= '0;
                drain_cnt <= '0;
            end else begin
                if (phase_run) phase_cnt <= phase_cnt + 1'b1;
                if (sb_write)  load_cnt  <= load_cnt + 1'b1;
                if (rsb_read)  drain_cnt <= drain_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        arr_clear  = 1'b0;
        a_ready    = 1'b0;
        sb_write   = 1'b0;
        sb_row_ptr = '0;
        sb_enable  = 1'b0;
        rsb_enable = 1'b0;
        rsb_write  = 1'b0;
        rsb_read   = 1'b0;
        c_valid    = 1'b0;
        c_row_idx  = '0;
        busy       = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                // Reset has priority, so a start seen during reset must not pulse arr_clear.
                if (start && !rst) begin
                    arr_clear  = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                a_ready    = 1'b1;
                sb_write   = a_valid;
                sb_row_ptr = load_cnt;
                if (a_valid && (load_cnt == ROW_LAST)) state_next = S_STREAM;
            end
            S_STREAM: begin
                sb_enable = 1'b1;
                if (phase_cnt == SKEW_LAST) state_next = (WAIT_CYCLES == 0) ? S_UNLOAD : S_WAIT;
            end
            S_WAIT: begin
                if (phase_cnt == WAIT_LAST) state_next = S_UNLOAD;
            end
            S_UNLOAD: begin
                rsb_enable = 1'b1;
                rsb_write  = 1'b1;
                if (phase_cnt == SKEW_LAST) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                c_valid   = 1'b1;
                rsb_read  = c_ready;
                c_row_idx = ROW_LAST - drain_cnt;
                if (c_ready && (drain_cnt == ROW_LAST)) state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_systolic_job_controller.sv
// Directed bench for systolic_job_controller (N=8, ARRAY_LATENCY=1); cycle k=0 is the first LOAD cycle.
module tb_systolic_job_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       arr_clear;
    logic       a_valid;
    logic       a_ready;
    logic       sb_write;
    logic [2:0] sb_row_ptr;
    logic       sb_enable;
    logic       rsb_enable;
    logic       rsb_write;
    logic       rsb_read;
    logic       c_valid;
    logic       c_ready;
    logic [2:0] c_row_idx;
    logic [15:0] obs;

    int checks = 0;
    int errors = 0;

    systolic_job_controller #(
        .ARRAY_SIZE   (8),
        .ARRAY_LATENCY(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .arr_clear (arr_clear),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .sb_write  (sb_write),
        .sb_row_ptr(sb_row_ptr),
        .sb_enable (sb_enable),
        .rsb_enable(rsb_enable),
        .rsb_write (rsb_write),
        .rsb_read  (rsb_read),
        .c_valid   (c_valid),
        .c_ready   (c_ready),
        .c_row_idx (c_row_idx)
    );

    assign obs = {busy, done, arr_clear, a_ready, sb_write, sb_enable, rsb_enable,
                  rsb_write, rsb_read, c_valid, sb_row_ptr, c_row_idx};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hand-derived schedule for an unstalled job: LOAD 0..7, STREAM 8..22, WAIT 23..30,
    // UNLOAD 31..45, DRAIN 46..53, DONE 54, IDLE 55. k = -1 is the start cycle.
    function automatic logic [15:0] exp_nom(input int k);
        logic       e_busy, e_done, e_clr, e_ar, e_sbw, e_sbe, e_rse, e_rsw, e_rsr, e_cv;
        logic [2:0] e_ptr, e_idx;
        {e_busy, e_done, e_clr, e_ar, e_sbw, e_sbe, e_rse, e_rsw, e_rsr, e_cv} = '0;
        e_ptr = '0;
        e_idx = '0;
        if (k < 0) begin
            e_clr = 1'b1;
        end else if (k < 8) begin
            {e_busy, e_ar, e_sbw} = 3'b111;
            e_ptr = 3'(k);
        end else if (k < 23) begin
            {e_busy, e_sbe} = 2'b11;
        end else if (k < 31) begin
            e_busy = 1'b1;
        end else if (k < 46) begin
            {e_busy, e_rse, e_rsw} = 3'b111;
        end else if (k < 54) begin
            {e_busy, e_cv, e_rsr} = 3'b111;
            e_idx = 3'(53 - k);
        end else if (k == 54) begin
            {e_busy, e_done} = 2'b11;
        end
        return {e_busy, e_done, e_clr, e_ar, e_sbw, e_sbe, e_rse, e_rsw, e_rsr, e_cv, e_ptr, e_idx};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a_valid = 1'b0; c_ready = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL reset_cycle1 got %h expected %h", obs, 16'h0000);
        end
        @(negedge clk); start = 1'b1; #1;
        checks++;
        if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL reset_with_start got %h expected %h", obs, 16'h0000);
        end
        @(negedge clk); rst = 1'b0; start = 1'b0; #1;
        checks++;
        if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL after_reset_idle got %h expected %h", obs, 16'h0000);
        end
    endtask

    task automatic test_nominal(input string tag);
        @(negedge clk); start = 1'b1; a_valid = 1'b1; c_ready = 1'b1; #1;
        checks++;
        if (obs !== exp_nom(-1)) begin
            errors++;
            $display("FAIL %s start_cycle got %h expected %h", tag, obs, exp_nom(-1));
        end
        for (int k = 0; k <= 55; k++) begin
            @(negedge clk); start = 1'b0; #1;
            checks++;
            if (obs !== exp_nom(k)) begin
                errors++;
                $display("FAIL %s cycle %0d got %h expected %h", tag, k, obs, exp_nom(k));
            end
        end
    endtask

    task automatic test_avalid_toggle();
        int done_k = -1;
        int writes = 0;
        @(negedge clk); start = 1'b1; a_valid = 1'b0; c_ready = 1'b1; #1;
        for (int unsigned j = 0; j <= 15; j++) begin
            @(negedge clk); start = 1'b0; a_valid = (j % 2 == 0); #1;
            if (sb_write === 1'b1) writes++;
            if (j < 15) begin
                checks++;
                if (a_ready !== 1'b1 || sb_write !== a_valid) begin
                    errors++;
                    $display("FAIL toggle_write j=%0d got a_ready=%b sb_write=%b expected 1 %b",
                             j, a_ready, sb_write, a_valid);
                end
                if (a_valid) begin
                    checks++;
                    if (sb_row_ptr !== 3'(j / 2)) begin
                        errors++;
                        $display("FAIL toggle_ptr j=%0d got %0d expected %0d", j, sb_row_ptr, j / 2);
                    end
                end
            end else begin
                checks++;
                if (sb_enable !== 1'b1 || a_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL toggle_load_len got sb_enable=%b a_ready=%b expected 1 0",
                             sb_enable, a_ready);
                end
            end
        end
        checks++;
        if (writes != 8) begin
            errors++;
            $display("FAIL toggle_write_count got %0d expected 8", writes);
        end
        a_valid = 1'b1;
        for (int k = 16; k < 200 && done_k < 0; k++) begin
            @(negedge clk); #1;
            if (done === 1'b1) done_k = k;
        end
        checks++;
        if (done_k != 61) begin
            errors++;
            $display("FAIL toggle_done_cycle got %0d expected 61", done_k);
        end
    endtask

    task automatic test_c_stall();
        int reads  = 0;
        int done_k = -1;
        int e_idx;
        @(negedge clk); start = 1'b1; a_valid = 1'b1; c_ready = 1'b1; #1;
        for (int k = 0; k <= 58; k++) begin
            @(negedge clk); start = 1'b0; c_ready = !(k >= 48 && k <= 50); #1;
            if (rsb_read === 1'b1) reads++;
            if (done === 1'b1 && done_k < 0) done_k = k;
            if (k >= 46 && k <= 56) begin
                e_idx = (k < 48) ? 53 - k : ((k <= 51) ? 5 : 56 - k);
                checks++;
                if (c_valid !== 1'b1 || rsb_read !== c_ready || c_row_idx !== 3'(e_idx)) begin
                    errors++;
                    $display("FAIL stall_drain k=%0d got c_valid=%b rsb_read=%b idx=%0d expected 1 %b %0d",
                             k, c_valid, rsb_read, c_row_idx, c_ready, e_idx);
                end
            end
        end
        checks++;
        if (reads != 8) begin
            errors++;
            $display("FAIL stall_read_count got %0d expected 8", reads);
        end
        checks++;
        if (done_k != 57) begin
            errors++;
            $display("FAIL stall_done_cycle got %0d expected 57", done_k);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle_after got busy=%b expected 0", busy);
        end
        c_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        @(negedge clk); start = 1'b1; a_valid = 1'b1; c_ready = 1'b1; #1;
        for (int k = 0; k <= 111; k++) begin
            @(negedge clk); start = (k == 10 || k == 54 || k == 55); #1;
            if (k == 10 || k == 11) begin
                checks++;
                if (arr_clear !== 1'b0 || sb_enable !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_stream_start k=%0d got clr=%b sb_enable=%b busy=%b expected 0 1 1",
                             k, arr_clear, sb_enable, busy);
                end
            end else if (k == 54) begin
                checks++;
                if (done !== 1'b1 || arr_clear !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_done_start got done=%b clr=%b expected 1 0", done, arr_clear);
                end
            end else if (k == 55) begin
                checks++;
                if (busy !== 1'b0 || arr_clear !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_restart got busy=%b clr=%b expected 0 1", busy, arr_clear);
                end
            end else if (k >= 56) begin
                checks++;
                if (obs !== exp_nom(k - 56)) begin
                    errors++;
                    $display("FAIL b2b_job2 cycle %0d got %h expected %h", k - 56, obs, exp_nom(k - 56));
                end
            end
        end
    endtask

    task automatic test_reset_mid_job();
        @(negedge clk); start = 1'b1; a_valid = 1'b1; c_ready = 1'b1; #1;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk); start = 1'b0; rst = (k == 12); #1;
        end
        checks++;
        if (sb_enable !== 1'b1) begin
            errors++;
            $display("FAIL midrst_in_stream got sb_enable=%b expected 1", sb_enable);
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_idle got %h expected %h", obs, 16'h0000);
        end
        test_nominal("after_midrst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_nominal("nominal");
        test_avalid_toggle();
        test_c_stall();
        test_back_to_back();
        test_reset_mid_job();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
